regfile_mp: RTL and testbench

Parametrised multi-port register file for the dual-issue core. It generalises the datapath width, depth and number of read/write ports, and adds four things: deterministic write-conflict priority, optional write-to-read bypass, a per-register pending scoreboard for issue hazard checks, and a sequenced soft-clear. It sits between decode/issue (reads, pending set) and writeback (writes).

---
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with write-conflict priority, optional write-to-read bypass,
// a per-register pending scoreboard and a sequenced soft-clear.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rpend,
  input  logic [NUM_WR-1:0]          iss_v,
  input  logic [NUM_WR*ADDR_W-1:0]   iss_addr,
  input  logic                       clr_req,
  output logic                       clr_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]    pend_q, pend_d;
  logic [ADDR_W-1:0]   wa;
  logic [ADDR_W-1:0]   ia;
  logic [ADDR_W-1:0]   ra;

  assign clr_busy = (state_q == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= regs_d[k];
    end
  end

  // Ascending port order lets the youngest (highest-indexed) writer win; marks follow writes so set beats clear.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wa      = '0;
    ia      = '0;
    for (int k = 0; k < DEPTH; k++) regs_d[k] = regs_q[k];

    if (state_q == CLEAR) begin
      regs_d[cnt_q] = '0;
      pend_d[cnt_q] = 1'b0;
      cnt_d         = cnt_q + 1'b1;
      if (cnt_q == LAST_ADDR) state_d = IDLE;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        wa = waddr[j*ADDR_W +: ADDR_W];
        if (we[j] && (wa != '0)) begin
          regs_d[wa] = wdata[j*DATA_W +: DATA_W];
          pend_d[wa] = 1'b0;
        end
      end
      for (int j = 0; j < NUM_WR; j++) begin
        ia = iss_addr[j*ADDR_W +: ADDR_W];
        if (iss_v[j] && (ia != '0)) pend_d[ia] = 1'b1;
      end
      if (clr_req) begin
        state_d = CLEAR;
        cnt_d   = ADDR_W'(1);
      end
    end
  end

  always_comb begin
    rdata = '0;
    rpend = '0;
    ra    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = raddr[i*ADDR_W +: ADDR_W];
      rdata[i*DATA_W +: DATA_W] = regs_q[ra];
      rpend[i] = pend_q[ra];
      if ((BYPASS != 0) && !clr_busy && (ra != '0)) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (we[j] && (waddr[j*ADDR_W +: ADDR_W] == ra)) begin
            rdata[i*DATA_W +: DATA_W] = wdata[j*DATA_W +: DATA_W];
            rpend[i] = 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing instance.
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   we, we_n;
  logic [9:0]   waddr, waddr_n;
  logic [63:0]  wdata, wdata_n;
  logic [19:0]  raddr, raddr_n;
  logic [127:0] rdata, rdata_n;
  logic [3:0]   rpend, rpend_n;
  logic [1:0]   iss_v, iss_v_n;
  logic [9:0]   iss_addr, iss_addr_n;
  logic         clr_req, clr_req_n;
  logic         clr_busy, clr_busy_n;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rpend(rpend),
    .iss_v(iss_v), .iss_addr(iss_addr), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .we(we_n), .waddr(waddr_n), .wdata(wdata_n),
    .raddr(raddr_n), .rdata(rdata_n), .rpend(rpend_n),
    .iss_v(iss_v_n), .iss_addr(iss_addr_n), .clr_req(clr_req_n), .clr_busy(clr_busy_n)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd(input int p);
    return rdata[p*32 +: 32];
  endfunction

  task automatic write1(input logic [4:0] a, input logic [31:0] d);
    we = 2'b01; waddr[4:0] = a; wdata[31:0] = d;
    @(negedge clk);
    we = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    we = '0; waddr = '0; wdata = '0; raddr = '0; iss_v = '0; iss_addr = '0; clr_req = 1'b0;
    we_n = '0; waddr_n = '0; wdata_n = '0; raddr_n = '0; iss_v_n = '0; iss_addr_n = '0; clr_req_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state on every address and port
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < 4; p++) raddr[p*5 +: 5] = 5'(a + p);
      #1;
      for (int p = 0; p < 4; p++) begin
        chk("rst_rdata", rd(p), 32'h0);
        chk("rst_rpend", {31'b0, rpend[p]}, 32'h0);
      end
    end
    chk("rst_busy", {31'b0, clr_busy}, 32'h0);

    // Address 0 is hard-wired zero
    @(negedge clk);
    raddr = '0;
    we = 2'b01; waddr = '0; wdata[31:0] = 32'hFFFF_FFFF;
    #1 chk("r0_same", rd(0), 32'h0);
    @(negedge clk);
    we = 2'b00;
    #1 chk("r0_next", rd(0), 32'h0);

    // Same-address conflict: port 1 wins, bypassed the same cycle
    raddr[9:5] = 5'd5;
    we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'h2222_2222, 32'h1111_1111};
    #1 chk("conf_bypass", rd(1), 32'h2222_2222);
    @(negedge clk);
    we = 2'b00;
    #1 chk("conf_stored", rd(1), 32'h2222_2222);

    // Non-bypassing instance returns old value in the write cycle
    raddr_n[14:10] = 5'd7;
    we_n = 2'b01; waddr_n[4:0] = 5'd7; wdata_n[31:0] = 32'hA5A5_A5A5;
    #1 chk("nb_same", rdata_n[95:64], 32'h0);
    @(negedge clk);
    we_n = 2'b00;
    #1 chk("nb_next", rdata_n[95:64], 32'hA5A5_A5A5);

    // Scoreboard
    raddr[4:0] = 5'd9;
    iss_v = 2'b01; iss_addr[4:0] = 5'd9;
    #1 chk("pend_before", {31'b0, rpend[0]}, 32'h0);
    @(negedge clk);
    iss_v = 2'b00;
    #1 chk("pend_set", {31'b0, rpend[0]}, 32'h1);
    we = 2'b01; waddr[4:0] = 5'd9; wdata[31:0] = 32'h0000_0099;
    iss_v = 2'b10; iss_addr[9:5] = 5'd9;
    #1 chk("pend_bypass_mask", {31'b0, rpend[0]}, 32'h0);
    chk("pend_bypass_data", rd(0), 32'h0000_0099);
    @(negedge clk);
    we = 2'b00; iss_v = 2'b00;
    #1 chk("pend_set_wins", {31'b0, rpend[0]}, 32'h1);
    write1(5'd9, 32'h0000_0199);
    #1 chk("pend_cleared", {31'b0, rpend[0]}, 32'h0);
    chk("pend_wdata", rd(0), 32'h0000_0199);

    // Fill then clear
    for (int a = 1; a < 32; a++) write1(5'(a), 32'h1000_0000 | 32'(a));
    iss_v = 2'b01; iss_addr[4:0] = 5'd12;
    @(negedge clk);
    iss_v = 2'b00;
    raddr = {5'd12, 5'd31, 5'd20, 5'd4};
    #1 chk("fill_31", rd(2), 32'h1000_001F);
    chk("fill_pend12", {31'b0, rpend[3]}, 32'h1);
    clr_req = 1'b1;
    #1 chk("clr_busy_pre", {31'b0, clr_busy}, 32'h0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      we = 2'b00; clr_req = 1'b0;
      if (!clr_busy) break;
      n++;
      if (n == 5) begin
        we = 2'b01; waddr[4:0] = 5'd4; wdata[31:0] = 32'hDEAD_BEEF;
        #1 chk("clr_no_bypass", rd(0), 32'h0);
        chk("clr_stored_20", rd(1), 32'h1000_0014);
      end
      if (n == 8) clr_req = 1'b1;
    end
    chk("clr_len", 32'(n), 32'd31);
    for (int a = 0; a < 32; a++) begin
      raddr[4:0] = 5'(a);
      #1 chk("clr_data", rd(0), 32'h0);
      chk("clr_pend", {31'b0, rpend[0]}, 32'h0);
    end

    // Reset mid-clear
    @(negedge clk);
    write1(5'd25, 32'h0000_2525);
    write1(5'd3,  32'h0000_0303);
    clr_req = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      clr_req = 1'b0;
      if (clr_busy) n++;
      if (n == 10 || !clr_busy) break;
    end
    chk("abort_reached", 32'(n), 32'd10);
    rst = 1'b1;
    raddr = {5'd0, 5'd0, 5'd3, 5'd25};
    #1 chk("abort_busy", {31'b0, clr_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_r25", rd(0), 32'h0);
    chk("abort_r3", rd(1), 32'h0);
    write1(5'd3, 32'h0000_1234);
    #1 chk("post_abort_wr", rd(1), 32'h0000_1234);
    chk("post_abort_busy", {31'b0, clr_busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
